// File: rtl/rng_buffer.sv
// rng_buffer: samples the free-running RNG word into a small FIFO (optionally
// decimated) and serves fresh words to the management SoC over Wishbone.
//
// Ports:
//   clk        system clock (shared with the RNG core)
//   rst        asynchronous, active-low reset
//   rnd_in     32-bit RNG word
//   rnd_valid  rnd_in is valid this cycle
//   cyc/stb    Wishbone cycle/strobe
//   we         Wishbone write enable
//   sel        byte-lane 0 select (writes ignored when low)
//   adr        word address (0 DATA, 1 STATUS, 2 CTRL, 3 BOUND)
//   dat_w      write data
//   dat_r      read data, valid while ack=1, held otherwise
//   ack        single-cycle acknowledge, one cycle after the request
//   level      current FIFO occupancy
module rng_buffer #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DECIM      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           rnd_in,
  input  logic                  rnd_valid,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic                  sel,
  input  logic [31:0]           adr,
  input  logic [31:0]           dat_w,
  output logic [31:0]           dat_r,
  output logic                  ack,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  LW       = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]       LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]       LVL_ONE  = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [7:0]          CNT_LAST = 8'(DECIM - 1);

  logic [31:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic [7:0]            cnt_r;
  logic                  enable_r;
  logic                  underflow_r;
  logic [31:0]           bound_r;
  logic                  ack_r;
  logic [31:0]           dat_r_r;

  logic                  req_s;
  logic                  rd_req_s;
  logic                  wr_req_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  clear_s;
  logic                  sample_s;
  logic                  push_s;
  logic [31:0]           head_s;
  logic [63:0]           prod_s;
  logic [31:0]           reduced_s;
  logic [31:0]           status_s;
  logic [31:0]           rd_data_s;

  assign dat_r = dat_r_r;
  assign ack   = ack_r;
  assign level = level_r;

  // Bus request decode and FIFO push/pop qualification.
  always_comb begin
    // ack_r masks the request so each access gets exactly one ack.
    req_s    = cyc & stb & ~ack_r;
    rd_req_s = req_s & ~we;
    wr_req_s = req_s & we & sel;
    empty_s  = (level_r == {LW{1'b0}});
    full_s   = (level_r == LVL_FULL);
    pop_s    = rd_req_s & (adr == 32'd0) & ~empty_s;
    clear_s  = wr_req_s & (adr == 32'd2) & dat_w[1];
    sample_s = enable_r & rnd_valid & (cnt_r == CNT_LAST);
    // A same-edge pop frees the slot, so a full FIFO still accepts; clear wins.
    push_s   = sample_s & ~clear_s & (~full_s | pop_s);
  end

  // Range reduction and read-data multiplexer.
  always_comb begin
    head_s    = mem_r[rd_ptr_r];
    prod_s    = {32'd0, head_s} * {32'd0, bound_r};
    if (bound_r == 32'd0) begin
      reduced_s = head_s;
    end else begin
      reduced_s = 32'(prod_s >> 32);
    end
    status_s                 = 32'd0;
    status_s[DEPTH_LOG2:0]   = level_r;
    status_s[16]             = empty_s;
    status_s[17]             = full_s;
    status_s[18]             = underflow_r;
    status_s[19]             = enable_r;
    case (adr)
      32'd0: begin
        if (empty_s) begin
          rd_data_s = 32'd0;
        end else begin
          rd_data_s = reduced_s;
        end
      end
      32'd1:   rd_data_s = status_s;
      32'd2:   rd_data_s = {31'd0, enable_r};
      32'd3:   rd_data_s = bound_r;
      default: rd_data_s = 32'd0;
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= rnd_in;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (clear_s) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Decimation counter: wraps on the DECIM-th valid sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 8'd0;
    end else if (clear_s) begin
      cnt_r <= 8'd0;
    end else if (enable_r && rnd_valid) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

  // Control/status registers: enable, underflow flag, range bound.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_r    <= 1'b1;
      underflow_r <= 1'b0;
      bound_r     <= 32'd0;
    end else begin
      if (wr_req_s && (adr == 32'd2)) begin
        enable_r <= dat_w[0];
        if (dat_w[2]) begin
          underflow_r <= 1'b0;
        end
      end else if (rd_req_s && (adr == 32'd0) && empty_s) begin
        underflow_r <= 1'b1;
      end
      if (wr_req_s && (adr == 32'd3)) begin
        bound_r <= dat_w;
      end
    end
  end

  // Wishbone response: one-cycle ack, dat_r captured on the request edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r   <= 1'b0;
      dat_r_r <= 32'd0;
    end else begin
      ack_r <= req_s;
      if (req_s) begin
        dat_r_r <= rd_data_s;
      end
    end
  end

endmodule

// File: tb/tb_rng_buffer.sv
module tb_rng_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rnd_in;
  logic        rnd_valid;
  logic        rnd_valid4;
  logic        cyc, stb, we, sel, tgt;
  logic [31:0] adr, dat_w;
  logic        cyc0, cyc4;
  logic [31:0] dat_r0, dat_r4;
  logic        ack0, ack4;
  logic [3:0]  level0, level4;

  assign cyc0 = cyc & ~tgt;
  assign cyc4 = cyc & tgt;

  rng_buffer #(.DEPTH_LOG2(3), .DECIM(1)) dut0 (
    .clk(clk), .rst(rst), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
    .cyc(cyc0), .stb(stb), .we(we), .sel(sel), .adr(adr), .dat_w(dat_w),
    .dat_r(dat_r0), .ack(ack0), .level(level0)
  );

  rng_buffer #(.DEPTH_LOG2(3), .DECIM(4)) dut4 (
    .clk(clk), .rst(rst), .rnd_in(rnd_in), .rnd_valid(rnd_valid4),
    .cyc(cyc4), .stb(stb), .we(we), .sel(sel), .adr(adr), .dat_w(dat_w),
    .dat_r(dat_r4), .ack(ack4), .level(level4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of dut0 (DECIM = 1): a queue of stored words plus registers.
  logic [31:0] q[$];
  logic        m_en, m_uf, m_ack;
  logic [31:0] m_bound, m_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reduce(input logic [31:0] h, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, h} * {32'd0, b};
    if (b == 32'd0) return h;
    return p[63:32];
  endfunction

  function automatic logic [31:0] read_val(input logic [31:0] a);
    logic [31:0] s;
    case (a)
      32'd0: return (q.size() == 0) ? 32'd0 : reduce(q[0], m_bound);
      32'd1: begin
        s = 32'(q.size());
        s[16] = (q.size() == 0);
        s[17] = (q.size() == DEPTH);
        s[18] = m_uf;
        s[19] = m_en;
        return s;
      end
      32'd2: return {31'd0, m_en};
      32'd3: return m_bound;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_en = 1'b1; m_uf = 1'b0; m_ack = 1'b0; m_bound = 32'd0; m_dat = 32'd0;
  endtask

  // One clock: update the model from the current inputs, then compare dut0.
  task automatic cycle();
    logic        req, pop, clr, psh;
    logic [31:0] rv;
    req = cyc && stb && !tgt && !m_ack;
    rv  = read_val(adr);
    pop = req && !we && (adr == 32'd0) && (q.size() > 0);
    clr = req && we && sel && (adr == 32'd2) && dat_w[1];
    psh = m_en && rnd_valid && !clr && ((q.size() < DEPTH) || pop);
    if (req) begin
      m_dat = rv;
      if (!we && (adr == 32'd0) && (q.size() == 0)) m_uf = 1'b1;
      if (we && sel && (adr == 32'd2)) begin
        m_en = dat_w[0];
        if (dat_w[2]) m_uf = 1'b0;
      end
      if (we && sel && (adr == 32'd3)) m_bound = dat_w;
    end
    if (pop) void'(q.pop_front());
    if (psh) q.push_back(rnd_in);
    if (clr) q.delete();
    m_ack = req;
    @(posedge clk);
    #1;
    chk("level", {28'd0, level0}, 32'(q.size()));
    chk("ack", {31'd0, ack0}, {31'd0, m_ack});
    chk("dat_r", dat_r0, m_dat);
  endtask

  // Full Wishbone access (request edge + ack edge); rd is the acked data.
  task automatic bus(input logic t, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic s, output logic [31:0] rd);
    tgt = t; we = w; adr = a; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
    cycle();
    if (t) chk("ack4", {31'd0, ack4}, 32'd1);
    rd = t ? dat_r4 : dat_r0;
    cyc = 1'b0; stb = 1'b0;
    cycle();
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] e4[$];
    int          vc;
    rst = 1'b0; rnd_in = 32'd0; rnd_valid = 1'b0; rnd_valid4 = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 1'b1; tgt = 1'b0;
    adr = 32'd0; dat_w = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_level", {28'd0, level0}, 32'd0);
    chk("reset_ack", {31'd0, ack0}, 32'd0);
    chk("reset_dat", dat_r0, 32'd0);

    // 1: async reset while ack=1 and level=5
    rnd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rnd_in = $urandom;
      cycle();
    end
    rnd_valid = 1'b0;
    tgt = 1'b0; we = 1'b0; adr = 32'd1; cyc = 1'b1; stb = 1'b1;
    cycle();
    chk("pre_rst_level", {28'd0, level0}, 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("async_ack", {31'd0, ack0}, 32'd0);
    chk("async_dat", dat_r0, 32'd0);
    chk("async_level", {28'd0, level0}, 32'd0);
    model_reset();
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    bus(1'b0, 1'b0, 32'd1, 32'd0, 1'b1, rd);
    chk("status_after_reset", rd, 32'h0009_0000);

    // 2: push 1,2,3 (third on the disabling CTRL write edge), then drain
    rnd_valid = 1'b1;
    rnd_in = 32'd1; cycle();
    rnd_in = 32'd2; cycle();
    rnd_in = 32'd3;
    bus(1'b0, 1'b1, 32'd2, 32'd0, 1'b1, rd);
    rnd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rd);
      chk("drain", rd, (i < 3) ? 32'(i + 1) : 32'd0);
    end
    bus(1'b0, 1'b0, 32'd1, 32'd0, 1'b1, rd);
    chk("underflow_set", {31'd0, rd[18]}, 32'd1);
    bus(1'b0, 1'b1, 32'd2, 32'd5, 1'b1, rd);
    bus(1'b0, 1'b0, 32'd1, 32'd0, 1'b1, rd);
    chk("ctrl5_status", rd, 32'h0009_0000);

    // 3: fill beyond depth, reads return the first 8 words in order
    rnd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rnd_in = $urandom;
      cycle();
    end
    rnd_valid = 1'b0;
    chk("full_level", {28'd0, level0}, 32'd8);
    bus(1'b0, 1'b0, 32'd1, 32'd0, 1'b1, rd);
    chk("full_flag", {31'd0, rd[17]}, 32'd1);
    for (int i = 0; i < 8; i++) bus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rd);

    // 4: range reduction
    bus(1'b0, 1'b1, 32'd3, 32'd6, 1'b1, rd);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'h8000_0000 : (i == 2) ? 32'd0 : 32'hDEAD_BEEF;
      if (i == 3) bus(1'b0, 1'b1, 32'd3, 32'd0, 1'b1, rd);
      rnd_in = w; rnd_valid = 1'b1;
      cycle();
      rnd_valid = 1'b0;
      bus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rd);
      chk("reduce", rd, (i == 0) ? 32'd5 : (i == 1) ? 32'd3 : (i == 2) ? 32'd0 : 32'hDEAD_BEEF);
    end

    // 6: full + pop on a push edge; clear coinciding with a push
    rnd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rnd_in = $urandom;
      cycle();
    end
    rnd_in = 32'h1234_5678;
    bus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rd);
    chk("pop_push_full_level", {28'd0, level0}, 32'd8);
    rnd_valid = 1'b0;
    rnd_valid = 1'b1;
    tgt = 1'b0; we = 1'b1; adr = 32'd2; dat_w = 32'd3; sel = 1'b1; cyc = 1'b1; stb = 1'b1;
    cycle();
    chk("clear_wins", {28'd0, level0}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    rnd_valid = 1'b0;
    cycle();

    // 5: DECIM=4 instance, plain run then a 2-cycle valid gap
    for (int run = 0; run < 2; run++) begin
      vc = 0;
      e4.delete();
      for (int k = 0; k < 14; k++) begin
        rnd_in = 32'(k);
        rnd_valid4 = !(run == 1 && (k == 5 || k == 6));
        if (rnd_valid4) begin
          if (vc % 4 == 3) e4.push_back(32'(k));
          vc++;
        end
        cycle();
      end
      rnd_valid4 = 1'b0;
      chk("dec4_level", {28'd0, level4}, 32'(e4.size()));
      for (int i = 0; i < 3; i++) begin
        bus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, rd);
        chk("dec4_word", rd, e4[i]);
        if (run == 1 && i == 1) chk("dec4_gap", rd, 32'd9);
      end
      bus(1'b1, 1'b1, 32'd2, 32'd3, 1'b1, rd);
    end

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      int op;
      logic [31:0] d;
      rnd_in = $urandom;
      rnd_valid = ($urandom_range(0, 2) != 0);
      op = $urandom_range(0, 10);
      case (op)
        4, 5:  bus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rd);
        6:     bus(1'b0, 1'b0, 32'd1, 32'd0, 1'b1, rd);
        7: begin
          d = {29'd0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) != 0)};
          bus(1'b0, 1'b1, 32'd2, d, 1'b1, rd);
        end
        8: begin
          d = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
          bus(1'b0, 1'b1, 32'd3, d, 1'b1, rd);
        end
        9: bus(1'b0, $urandom_range(0, 1) == 1, 32'($urandom_range(2, 40)), $urandom, 1'b1, rd);
        10: bus(1'b0, 1'b1, 32'($urandom_range(0, 3)), $urandom, 1'b0, rd);
        default: cycle();
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
